rgb565_pixel_feeder: RTL
========================

Name: rgb565_pixel_feeder

Overview:
- Elastic buffer directly upstream of the HDMI RGB video pattern generator; supplies its 16-bit RGB565 PIXEL input.
- Accepts pixels from the vision pipeline over a valid/ready stream, with a start-of-frame marker on each frame's first pixel.
- Pops one pixel per generator request and keeps frames aligned to the generator's frame start.
- On underflow, outputs a fixed colour instead of stalling the display.

Parameters:
- DEPTH, 1024, FIFO entries; power of two, min 16.
- PREFILL, 256, entries required before the first pop after frame alignment; 1 ≤ PREFILL ≤ DEPTH.
- UNDERFLOW_COLOR, 16'h0000, RGB565 value driven when no valid pixel is available.

Ports:
- clk  in  1  pixel clock (same clock as the pattern generator)
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  feeder can accept a pixel
- s_data  in  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B
- s_sof  in  1  qualifies s_data as the first pixel of a frame
- frame_start  in  1  one-cycle pulse from the generator at vertical sync start
- pix_req  in  1  generator requests the next active pixel; asserted the cycle before de
- PIXEL  out  16  pixel to the generator; registered
- underflow  out  1  sticky; set on any substituted pixel; cleared by frame_start
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- underflow_cnt  out  16  stats counter (see Optional Feature)
- drop_cnt  out  16  stats counter (see Optional Feature)

Behaviour:
- Reset values (async, reset_n=0): FIFO empty; state=ALIGN; PIXEL=UNDERFLOW_COLOR; underflow=0; level=0; counters=0; s_ready=0.
- Storage: each entry is 17 bits {sof, data}.
- Push: on s_valid && s_ready. s_ready = !full, except in DISCARD.
- Read latency: 1 cycle. PIXEL updates on the clock edge after pix_req, and holds its value when pix_req=0.
- Simultaneous push and pop keep level unchanged. Push when full cannot occur because s_ready=0. Pointers wrap modulo DEPTH.
- State ALIGN (after reset and after every frame_start):
  - Pop and discard head entries, one per cycle, until the head has sof=1 or the FIFO is empty.
  - Each discarded entry increments drop_cnt.
  - If the FIFO is empty, go to DISCARD. If the head has sof=1, go to FILL.
- State DISCARD:
  - s_ready=1; accepted inputs with s_sof=0 are dropped and counted.
  - An input with s_sof=1 is written to the FIFO; go to FILL.
- State FILL:
  - Normal push; no pops.
  - Go to RUN when level ≥ PREFILL, or when any entry behind the head has sof=1 (short frame).
  - pix_req in FILL drives UNDERFLOW_COLOR and sets underflow.
- State RUN, on pix_req:
  - FIFO non-empty and head sof=0, or head sof=1 on the first request after alignment: pop; PIXEL=data.
  - Head sof=1 on a later request (next frame arrived early): do not pop; PIXEL=UNDERFLOW_COLOR; set underflow. The head is kept for the next frame.
  - FIFO empty: PIXEL=UNDERFLOW_COLOR; set underflow.
- frame_start handling:
  - In any state, frame_start forces ALIGN on the next cycle and clears underflow.
  - frame_start has priority over a pix_req in the same cycle; that pix_req is ignored and PIXEL holds.
- Reset asserted mid-frame: immediate return to reset values; no partial pop completes.

Optional Feature:
- Macro: RGB565_PIXEL_FEEDER_STATS_EN.
- Defined:
  - underflow_cnt increments, saturating at 16'hFFFF, on every substituted pixel.
  - drop_cnt increments, saturating, on every discarded entry or input.
  - Both counters clear only on reset.
- Undefined: both ports are tied to 16'h0 and no counter logic is synthesised.

Decomposition:
- Shared package hdmi_pkg:
  - RGB565 field widths and bit positions.
  - Feeder state enum {ALIGN, DISCARD, FILL, RUN}.
  - Default UNDERFLOW_COLOR constant.
- Sub-module pixel_fifo_sync:
  - Single-clock, DEPTH x 17 FIFO with registered read port.
  - Outputs full, empty, level, head, and a "sof present behind head" flag.
- The top level holds the alignment FSM, output register, sticky flag and counters.

Test Plan:
- Reset, then push a 4-pixel frame 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF (sof on first) with PREFILL=4; pulse frame_start; issue 4 pix_req → PIXEL shows the same four values, each 1 cycle after its request; underflow=0.
- Push 3 pixels with sof=0, then a frame starting 16'h1234 with sof=1; pulse frame_start → 3 entries dropped (drop_cnt=3 with the macro); first PIXEL=16'h1234.
- Frame of 2 pixels, then 5 pix_req → pixels 1–2 output, then 3x UNDERFLOW_COLOR; underflow=1; underflow_cnt=3; next frame_start clears underflow.
- Hold s_valid=1 with no pix_req until full → s_ready=0 at level=DEPTH; level never exceeds DEPTH; no data corruption after draining.
- Next frame's sof reaches the head while requests continue → PIXEL=UNDERFLOW_COLOR and no pop; after frame_start, the first pix_req returns that sof pixel.
- Assert reset_n=0 mid-RUN, between clock edges → PIXEL=16'h0000 and level=0 immediately; state returns to ALIGN.

Source files
------------

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: definitions shared by the HDMI pixel path.
//   - RGB565 field widths and bit positions
//   - pixel FIFO entry layout {sof, data}
//   - pixel feeder FSM state encoding
//   - default colour substituted on underflow
package hdmi_pkg;

    localparam int RGB_W   = 16;
    localparam int R_W     = 5;
    localparam int G_W     = 6;
    localparam int B_W     = 5;
    localparam int R_LSB   = 11;
    localparam int G_LSB   = 5;
    localparam int B_LSB   = 0;
    localparam int ENTRY_W = RGB_W + 1;

    localparam logic [RGB_W-1:0] UNDERFLOW_COLOR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_ALIGN   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_FILL    = 2'd2,
        ST_RUN     = 2'd3
    } feeder_state_e;

    typedef struct packed {
        logic             sof;
        logic [RGB_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [RGB_W-1:0] rgb565_pack(input logic [R_W-1:0] r,
                                                     input logic [G_W-1:0] g,
                                                     input logic [B_W-1:0] b);
        logic [RGB_W-1:0] px;
        px = '0;
        px[R_LSB +: R_W] = r;
        px[G_LSB +: G_W] = g;
        px[B_LSB +: B_W] = b;
        return px;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pixel_fifo_sync.sv
// pixel_fifo_sync: single-clock DEPTH x 17 FIFO for the pixel feeder.
// The head entry is presented directly from the memory and is captured by
// the consumer's output register on the pop edge, giving one registered read.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, push_entry   write request and {sof, data}
//   pop                remove head entry (ignored when empty)
//   full, empty, level occupancy status
//   head               current head entry
//   sof_behind         some entry other than the head carries sof
module pixel_fifo_sync
    import hdmi_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fifo_entry_t   push_entry,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output fifo_entry_t   head,
    output logic          sof_behind
);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] cnt;
    logic [LW-1:0] sof_cnt;   // number of stored entries with sof=1
    logic          do_push, do_pop;
    logic          sof_in, sof_out;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign sof_in  = do_push && push_entry.sof;
    assign sof_out = do_pop && head.sof;

    // Head contents are meaningless when empty, so gate the flag.
    assign sof_behind = !empty && (sof_cnt > LW'(head.sof));

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            sof_cnt <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt     <= cnt + LW'(do_push) - LW'(do_pop);
            sof_cnt <= sof_cnt + LW'(sof_in) - LW'(sof_out);
        end
    end

endmodule

// File: rtl/rgb565_pixel_feeder.sv
// rgb565_pixel_feeder: elastic pixel buffer in front of the HDMI pattern
// generator. Aligns the buffered stream to the generator's frame start,
// pops one pixel per pix_req and substitutes UNDERFLOW_COLOR when no valid
// pixel is available.
// Optional statistics counters: define RGB565_PIXEL_FEEDER_STATS_EN.
// Ports:
//   clk, reset_n            pixel clock, async active-low reset
//   s_valid/s_ready/s_data/s_sof   upstream pixel stream
//   frame_start             generator vsync pulse; realigns the buffer
//   pix_req                 generator pixel request (cycle before de)
//   PIXEL                   registered RGB565 output
//   underflow               sticky substitution flag, cleared by frame_start
//   level                   FIFO occupancy
//   underflow_cnt, drop_cnt saturating stats (zero when stats disabled)
// DEPTH must be a power of two >= 16; 1 <= PREFILL <= DEPTH.
module rgb565_pixel_feeder
    import hdmi_pkg::*;
#(
    parameter  int               DEPTH           = 1024,
    parameter  int               PREFILL         = 256,
    parameter  logic [RGB_W-1:0] UNDERFLOW_COLOR = UNDERFLOW_COLOR_DEF,
    localparam int               LW              = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RGB_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             frame_start,
    input  logic             pix_req,
    output logic [RGB_W-1:0] PIXEL,
    output logic             underflow,
    output logic [LW-1:0]    level,
    output logic [15:0]      underflow_cnt,
    output logic [15:0]      drop_cnt
);

    feeder_state_e state_q;
    logic          first_req_q;   // next RUN request may pop a sof head
    logic          ready_en_q;    // holds s_ready low through reset

    fifo_entry_t   head, push_entry;
    logic          full, empty, sof_behind;
    logic [LW-1:0] fifo_level;
    logic          accept, push, pop;
    logic          align_drop, run_pop, subst;

    assign s_ready = ready_en_q && ((state_q == ST_DISCARD) || !full);
    assign accept  = s_valid && s_ready;
    // In DISCARD only a frame's first pixel is stored.
    assign push    = accept && ((state_q != ST_DISCARD) || s_sof);
    assign push_entry = '{sof: s_sof, data: s_data};

    // frame_start wins over everything else in its cycle.
    assign align_drop = !frame_start && (state_q == ST_ALIGN) && !empty && !head.sof;
    assign run_pop    = !frame_start && pix_req && (state_q == ST_RUN) && !empty &&
                        (!head.sof || first_req_q);
    assign pop        = align_drop || run_pop;
    // A sof head on a later request belongs to the next frame: keep it.
    assign subst      = !frame_start && pix_req && !run_pop;

    pixel_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .level      (fifo_level),
        .head       (head),
        .sof_behind (sof_behind)
    );

    assign level = fifo_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ALIGN;
            first_req_q <= 1'b1;
            ready_en_q  <= 1'b0;
            PIXEL       <= UNDERFLOW_COLOR;
            underflow   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (frame_start) begin
                state_q     <= ST_ALIGN;
                first_req_q <= 1'b1;
                underflow   <= 1'b0;
            end else begin
                if (run_pop) begin
                    PIXEL       <= head.data;
                    first_req_q <= 1'b0;
                end else if (subst) begin
                    PIXEL     <= UNDERFLOW_COLOR;
                    underflow <= 1'b1;
                end
                case (state_q)
                    ST_ALIGN: begin
                        // A push landing in an empty FIFO is examined next
                        // cycle rather than skipped over.
                        if (empty && !push)
                            state_q <= ST_DISCARD;
                        else if (!empty && head.sof)
                            state_q <= ST_FILL;
                    end
                    ST_DISCARD: begin
                        if (accept && s_sof)
                            state_q <= ST_FILL;
                    end
                    ST_FILL: begin
                        if ((fifo_level >= LW'(PREFILL)) || sof_behind)
                            state_q <= ST_RUN;
                    end
                    ST_RUN:  state_q <= ST_RUN;
                    default: state_q <= ST_ALIGN;
                endcase
            end
        end
    end

`ifdef RGB565_PIXEL_FEEDER_STATS_EN
    logic        in_drop;
    logic [15:0] ucnt_q, dcnt_q;

    assign in_drop = accept && (state_q == ST_DISCARD) && !s_sof;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ucnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            if (subst)
                ucnt_q <= sat_inc16(ucnt_q);
            if (align_drop || in_drop)
                dcnt_q <= sat_inc16(dcnt_q);
        end
    end

    assign underflow_cnt = ucnt_q;
    assign drop_cnt      = dcnt_q;
`else
    assign underflow_cnt = 16'h0;
    assign drop_cnt      = 16'h0;
`endif

endmodule
